// File: rtl/iq_decimator_if.sv
// Sample-stream bus for iq_decimator: input handshake with flush, output handshake
// with saturation flag.
interface iq_decimator_if #(
  parameter int unsigned DATA_W = 5,
  parameter int unsigned OUT_W  = 5
) ();
  logic signed [DATA_W-1:0] in_data;
  logic                     in_valid;
  logic                     in_ready;
  logic                     flush;
  logic signed [OUT_W-1:0]  out_data;
  logic                     out_sat;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface

// File: rtl/iq_decimator.sv
// Integrate-and-dump decimator for one filtered I or Q channel: sums DECIM samples,
// scales by 2^GAIN_LOG2 / DECIM, saturates to OUT_W bits and queues into a 2-entry FIFO.
module iq_decimator #(
  parameter int unsigned DATA_W    = 5,
  parameter int unsigned OUT_W     = 5,
  parameter int unsigned DECIM     = 4,
  parameter int unsigned GAIN_LOG2 = 1
) (
  input  logic           clk,
  input  logic           resetn,
  iq_decimator_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DECIM);
  localparam int unsigned ACC_W = DATA_W + CNT_W;
  localparam int unsigned SHIFT = CNT_W - GAIN_LOG2;
  // One spare bit so both clamp limits are representable whatever OUT_W is.
  localparam int unsigned EXT_W = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;

  localparam logic [CNT_W-1:0] PhaseFirst = '0;
  localparam logic [CNT_W-1:0] PhaseLast  = CNT_W'(DECIM - 1);

  localparam logic signed [EXT_W-1:0] SatMax = EXT_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] SatMin = ~SatMax;

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic signed [EXT_W-1:0] scaled;
  logic [OUT_W-1:0]        res_data;
  logic                    res_sat;

  logic                    accept;
  logic                    push;
  logic                    pop;

  logic [OUT_W-1:0]        head_data_q, head_data_d;
  logic                    head_sat_q, head_sat_d;
  logic                    head_valid_q, head_valid_d;
  logic [OUT_W-1:0]        tail_data_q, tail_data_d;
  logic                    tail_sat_q, tail_sat_d;
  logic                    tail_valid_q, tail_valid_d;

  // Stall only when a dump is due and the FIFO has nowhere to put it.
  assign bus.in_ready  = !((cnt_q == PhaseLast) && head_valid_q && tail_valid_q);
  assign bus.out_data  = head_data_q;
  assign bus.out_sat   = head_sat_q;
  assign bus.out_valid = head_valid_q;

  assign accept = bus.in_valid && bus.in_ready;
  assign push   = accept && !bus.flush && (cnt_q == PhaseLast);
  assign pop    = head_valid_q && bus.out_ready;

  assign sample_ext = {{CNT_W{bus.in_data[DATA_W-1]}}, bus.in_data};
  assign sum        = acc_q + sample_ext;
  assign shifted    = sum >>> SHIFT;
  assign scaled     = {{(EXT_W - ACC_W){shifted[ACC_W-1]}}, shifted};

  always_comb begin
    res_sat  = 1'b0;
    res_data = scaled[OUT_W-1:0];
    if (scaled > SatMax) begin
      res_sat  = 1'b1;
      res_data = SatMax[OUT_W-1:0];
    end else if (scaled < SatMin) begin
      res_sat  = 1'b1;
      res_data = SatMin[OUT_W-1:0];
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (bus.flush) begin
      acc_d = '0;
      cnt_d = PhaseFirst;
    end else if (accept) begin
      if (cnt_q == PhaseLast) begin
        acc_d = '0;
        cnt_d = PhaseFirst;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Head register is the visible output; tail holds the second entry.
  always_comb begin
    head_data_d  = head_data_q;
    head_sat_d   = head_sat_q;
    head_valid_d = head_valid_q;
    tail_data_d  = tail_data_q;
    tail_sat_d   = tail_sat_q;
    tail_valid_d = tail_valid_q;
    if (pop) begin
      if (tail_valid_q) begin
        head_data_d  = tail_data_q;
        head_sat_d   = tail_sat_q;
        head_valid_d = 1'b1;
        tail_valid_d = 1'b0;
        if (push) begin
          tail_data_d  = res_data;
          tail_sat_d   = res_sat;
          tail_valid_d = 1'b1;
        end
      end else if (push) begin
        head_data_d  = res_data;
        head_sat_d   = res_sat;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (push) begin
      if (!head_valid_q) begin
        head_data_d  = res_data;
        head_sat_d   = res_sat;
        head_valid_d = 1'b1;
      end else begin
        tail_data_d  = res_data;
        tail_sat_d   = res_sat;
        tail_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q        <= '0;
      cnt_q        <= PhaseFirst;
      head_data_q  <= '0;
      head_sat_q   <= 1'b0;
      head_valid_q <= 1'b0;
      tail_data_q  <= '0;
      tail_sat_q   <= 1'b0;
      tail_valid_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      head_data_q  <= head_data_d;
      head_sat_q   <= head_sat_d;
      head_valid_q <= head_valid_d;
      tail_data_q  <= tail_data_d;
      tail_sat_q   <= tail_sat_d;
      tail_valid_q <= tail_valid_d;
    end
  end

endmodule

// File: tb/tb_iq_decimator.sv
// Bench for iq_decimator: vector table for block arithmetic plus sequences for
// back-pressure, flush and mid-block reset, with a scoreboard on the output port.
module tb_iq_decimator;
  localparam int unsigned DATA_W    = 5;
  localparam int unsigned OUT_W     = 5;
  localparam int unsigned DECIM     = 4;
  localparam int unsigned GAIN_LOG2 = 1;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  iq_decimator_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  iq_decimator #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .DECIM(DECIM), .GAIN_LOG2(GAIN_LOG2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int s0; int s1; int s2; int s3;
    int exp_data; int exp_sat;
  } vec_t;

  typedef struct {
    int data;
    int sat;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic send(input int d);
    int n = 0;
    bus.in_data  = DATA_W'(d);
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("send_timeout", n, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  // Output monitor: a pop happens at the next rising edge when valid & ready here.
  exp_t mon_e;
  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      check("scoreboard_nonempty", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("sb_data", int'($signed(bus.out_data)), mon_e.data);
        check("sb_sat", int'(bus.out_sat), mon_e.sat);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{1, 2, 3, 4, 5, 0};
    vecs[1]  = '{15, 15, 15, 15, 15, 1};
    vecs[2]  = '{-16, -16, -16, -16, -16, 1};
    vecs[3]  = '{-1, 0, 0, 0, -1, 0};
    vecs[4]  = '{1, 0, 0, 0, 0, 0};
    vecs[5]  = '{7, -3, 2, -8, -1, 0};
    vecs[6]  = '{8, 8, 0, 0, 8, 0};
    vecs[7]  = '{15, 15, 1, 0, 15, 0};
    vecs[8]  = '{15, 15, 3, 0, 15, 1};
    vecs[9]  = '{-16, -16, 0, 0, -16, 0};
    vecs[10] = '{-16, -16, -1, 0, -16, 1};

    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_data", int'($signed(bus.out_data)), 0);
    check("reset_out_sat", int'(bus.out_sat), 0);
    resetn = 1'b1;
    check("reset_in_ready", int'(bus.in_ready), 1);

    for (int i = 0; i < 11; i++) begin
      exp_q.push_back('{vecs[i].exp_data, vecs[i].exp_sat});
      send(vecs[i].s0);
      send(vecs[i].s1);
      send(vecs[i].s2);
      check($sformatf("vec%0d_valid_before_dump", i), int'(bus.out_valid), 0);
      send(vecs[i].s3);
      check($sformatf("vec%0d_valid_after_dump", i), int'(bus.out_valid), 1);
      check($sformatf("vec%0d_data", i), int'($signed(bus.out_data)), vecs[i].exp_data);
      check($sformatf("vec%0d_sat", i), int'(bus.out_sat), vecs[i].exp_sat);
      repeat (3) @(posedge clk);
      #1;
    end

    // Back-pressure: two full blocks fill the FIFO, third block stalls on its last sample.
    bus.out_ready = 1'b0;
    repeat (2) begin
      repeat (4) send(3);
      exp_q.push_back('{6, 0});
    end
    repeat (3) send(3);
    check("bp_in_ready_low", int'(bus.in_ready), 0);
    check("bp_head_data", int'($signed(bus.out_data)), 6);
    bus.in_data  = DATA_W'(3);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_stall", int'(bus.in_ready), 0);
      check("bp_hold_valid", int'(bus.out_valid), 1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_in_ready_after_pop", int'(bus.in_ready), 1);
    exp_q.push_back('{6, 0});
    send(3);
    repeat (6) @(posedge clk);
    #1;
    check("bp_drained", exp_q.size(), 0);

    // Flush discards a partial block; accepted sample in the flush cycle is dropped.
    send(7);
    send(7);
    bus.in_data  = DATA_W'(9);
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    exp_q.push_back('{8, 0});
    repeat (3) send(4);
    check("flush_no_early_output", int'(bus.out_valid), 0);
    send(4);
    check("flush_valid", int'(bus.out_valid), 1);
    check("flush_data", int'($signed(bus.out_data)), 8);
    repeat (4) @(posedge clk);
    #1;

    // Reset mid-block with one buffered result.
    bus.out_ready = 1'b0;
    repeat (4) send(1);
    send(5);
    send(5);
    check("prereset_valid", int'(bus.out_valid), 1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midreset_out_valid", int'(bus.out_valid), 0);
    check("midreset_out_data", int'($signed(bus.out_data)), 0);
    resetn = 1'b1;
    check("midreset_in_ready", int'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    exp_q.push_back('{5, 0});
    send(1);
    send(2);
    send(3);
    send(4);
    check("postreset_data", int'($signed(bus.out_data)), 5);

    repeat (6) @(posedge clk);
    #1;
    check("final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
